// File: rtl/aes_keyram_sched_ctrl_if.sv
// rtl/aes_keyram_sched_ctrl_if.sv - key-schedule RAM controller signal bundle (load, replay, RAM, zeroize)
interface aes_keyram_sched_ctrl_if #(
    parameter int RAM_DW     = 64,
    parameter int SLOTS      = 2,
    parameter int SLOT_DEPTH = 16
);
    localparam int WPR = 128 / RAM_DW;
    localparam int AW  = $clog2(SLOTS * SLOT_DEPTH * WPR);
    localparam int SW  = (SLOTS > 1) ? $clog2(SLOTS) : 1;

    logic              wr_start;
    logic [SW-1:0]     wr_slot;
    logic [1:0]        key_len;
    logic              wr_valid;
    logic [RAM_DW-1:0] wr_data;
    logic              wr_busy;
    logic [SLOTS-1:0]  slot_valid;
    logic              rd_start;
    logic [SW-1:0]     rd_slot;
    logic              rd_dec;
    logic              rd_next;
    logic [127:0]      key_round;
    logic              key_valid;
    logic              key_last;
    logic              rd_done;
    logic              cmd_err;
    logic              ram_we;
    logic [AW-1:0]     ram_addr;
    logic [RAM_DW-1:0] ram_wdata;
    logic [RAM_DW-1:0] ram_rdata;
    logic              zero_req;
    logic [SW-1:0]     zero_slot;

    modport slave (
        input  wr_start, wr_slot, key_len, wr_valid, wr_data,
        input  rd_start, rd_slot, rd_dec, rd_next, ram_rdata, zero_req, zero_slot,
        output wr_busy, slot_valid, key_round, key_valid, key_last, rd_done, cmd_err,
        output ram_we, ram_addr, ram_wdata
    );

    modport master (
        output wr_start, wr_slot, key_len, wr_valid, wr_data,
        output rd_start, rd_slot, rd_dec, rd_next, ram_rdata, zero_req, zero_slot,
        input  wr_busy, slot_valid, key_round, key_valid, key_last, rd_done, cmd_err,
        input  ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/aes_keyram_sched_ctrl.sv
// rtl/aes_keyram_sched_ctrl.sv - multi-slot AES round-key RAM loader/replayer; KEYRAM_ZEROIZE_EN adds slot zeroize
module aes_keyram_sched_ctrl #(
    parameter int RAM_DW     = 64,
    parameter int SLOTS      = 2,
    parameter int SLOT_DEPTH = 16
) (
    input logic                    clk,
    input logic                    kill_n,
    aes_keyram_sched_ctrl_if.slave bus
);
    localparam int WPR        = 128 / RAM_DW;
    localparam int SLOT_WORDS = SLOT_DEPTH * WPR;
    localparam int AW         = $clog2(SLOTS * SLOT_WORDS);
    localparam int SW         = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int CW         = $clog2(SLOT_WORDS + 1);
    localparam int RW         = $clog2(SLOT_DEPTH);
    localparam int IW         = (WPR > 1) ? $clog2(WPR) : 1;
    localparam logic [IW-1:0] ISS_LAST  = IW'(WPR - 1);
    localparam logic [AW-1:0] SLOT_BASE = AW'(SLOT_WORDS);

`ifdef KEYRAM_ZEROIZE_EN
    typedef enum logic [1:0] {W_IDLE, W_LOAD, W_ZERO} wr_st_t;
`else
    typedef enum logic [1:0] {W_IDLE, W_LOAD} wr_st_t;
`endif
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_FILL, R_HOLD} rd_st_t;

    wr_st_t           wr_st_q, wr_st_d;
    logic [SW-1:0]    wr_slot_q, wr_slot_d;
    logic [CW-1:0]    wr_cnt_q, wr_cnt_d;
    logic [RW-1:0]    nr_q [SLOTS];
    logic [RW-1:0]    nr_d [SLOTS];
    logic [SLOTS-1:0] slot_valid_q, slot_valid_d;
    rd_st_t           rd_st_q, rd_st_d;
    logic [SW-1:0]    rd_slot_q, rd_slot_d;
    logic             rd_dec_q, rd_dec_d;
    logic [RW-1:0]    round_q, round_d;
    logic [IW-1:0]    iss_q, iss_d;
    logic             tag_v_q, tag_v_d;
    logic [IW-1:0]    tag_w_q, tag_w_d;
    logic [127:0]     key_q, key_d;
    logic             key_valid_q, key_valid_d;
    logic             rd_done_q, rd_done_d;
    logic             cmd_err_q, cmd_err_d;

    logic load_go, zero_go, zero_rej, zero_we, wr_fire, ram_we;
    logic rd_issue, rd_clash, rd_abort, key_last;
    logic [CW-1:0] wr_last;
    logic [AW-1:0] wr_addr, rd_addr;

    always_comb begin
        load_go  = bus.wr_start && (bus.key_len != 2'd3);
`ifdef KEYRAM_ZEROIZE_EN
        zero_go  = bus.zero_req && (wr_st_q == W_IDLE) && !bus.wr_start;
        zero_rej = bus.zero_req && !zero_go;
        zero_we  = (wr_st_q == W_ZERO);
`else
        zero_go  = 1'b0;
        zero_rej = 1'b0;
        zero_we  = 1'b0;
`endif
        wr_fire  = (wr_st_q == W_LOAD) && bus.wr_valid && !load_go;
        ram_we   = wr_fire || zero_we;
        wr_last  = CW'((int'(nr_q[wr_slot_q]) + 1) * WPR - 1);
        wr_addr  = AW'(wr_slot_q) * SLOT_BASE + AW'(wr_cnt_q);
        rd_addr  = AW'(rd_slot_q) * SLOT_BASE + AW'(round_q) * AW'(WPR) + AW'(iss_q);
        // A RAM write owns the single port; the pending read simply waits a cycle.
        rd_issue = (rd_st_q == R_FETCH) && !ram_we;
        rd_clash = (load_go && (bus.wr_slot == bus.rd_slot)) ||
                   (zero_go && (bus.zero_slot == bus.rd_slot));
        rd_abort = (rd_st_q != R_IDLE) &&
                   ((load_go && (bus.wr_slot == rd_slot_q)) ||
                    (zero_go && (bus.zero_slot == rd_slot_q)));
        key_last = key_valid_q && (rd_dec_q ? (round_q == '0) : (round_q == nr_q[rd_slot_q]));
    end

    always_comb begin
        wr_st_d      = wr_st_q;
        wr_slot_d    = wr_slot_q;
        wr_cnt_d     = wr_cnt_q;
        nr_d         = nr_q;
        slot_valid_d = slot_valid_q;
        if (load_go) begin
            slot_valid_d[bus.wr_slot] = 1'b0;
            nr_d[bus.wr_slot]         = RW'(10 + 2 * int'(bus.key_len));
            wr_slot_d                 = bus.wr_slot;
            wr_cnt_d                  = '0;
            wr_st_d                   = W_LOAD;
        end else if (wr_fire) begin
            wr_cnt_d = wr_cnt_q + 1'b1;
            if (wr_cnt_q == wr_last) begin
                wr_st_d                 = W_IDLE;
                slot_valid_d[wr_slot_q] = 1'b1;
            end
        end
`ifdef KEYRAM_ZEROIZE_EN
        else if (zero_go) begin
            slot_valid_d[bus.zero_slot] = 1'b0;
            wr_slot_d                   = bus.zero_slot;
            wr_cnt_d                    = '0;
            wr_st_d                     = W_ZERO;
        end else if (wr_st_q == W_ZERO) begin
            wr_cnt_d = wr_cnt_q + 1'b1;
            if (wr_cnt_q == CW'(SLOT_WORDS - 1)) wr_st_d = W_IDLE;
        end
`endif
    end

    always_comb begin
        rd_st_d     = rd_st_q;
        rd_slot_d   = rd_slot_q;
        rd_dec_d    = rd_dec_q;
        round_d     = round_q;
        iss_d       = iss_q;
        key_d       = key_q;
        key_valid_d = key_valid_q;
        tag_v_d     = 1'b0;
        tag_w_d     = iss_q;
        rd_done_d   = 1'b0;
        cmd_err_d   = (bus.wr_start && (bus.key_len == 2'd3)) || zero_rej;
        // Read data belongs to whatever word the tag says was issued last cycle.
        if (tag_v_q) key_d[int'(tag_w_q) * RAM_DW +: RAM_DW] = bus.ram_rdata;
        case (rd_st_q)
            R_IDLE: begin
                if (bus.rd_start) begin
                    if (slot_valid_q[bus.rd_slot] && !rd_clash) begin
                        rd_slot_d = bus.rd_slot;
                        rd_dec_d  = bus.rd_dec;
                        round_d   = bus.rd_dec ? nr_q[bus.rd_slot] : '0;
                        iss_d     = '0;
                        rd_st_d   = R_FETCH;
                    end else begin
                        cmd_err_d = 1'b1;
                    end
                end
            end
            R_FETCH: begin
                if (rd_issue) begin
                    tag_v_d = 1'b1;
                    if (iss_q == ISS_LAST) rd_st_d = R_FILL;
                    else iss_d = iss_q + 1'b1;
                end
            end
            R_FILL: begin
                if (tag_v_q && (tag_w_q == ISS_LAST)) begin
                    rd_st_d     = R_HOLD;
                    key_valid_d = 1'b1;
                end
            end
            R_HOLD: begin
                if (bus.rd_next) begin
                    key_valid_d = 1'b0;
                    if (key_last) begin
                        rd_st_d   = R_IDLE;
                        rd_done_d = 1'b1;
                    end else begin
                        round_d = rd_dec_q ? round_q - 1'b1 : round_q + 1'b1;
                        iss_d   = '0;
                        rd_st_d = R_FETCH;
                    end
                end
            end
            default: rd_st_d = R_IDLE;
        endcase
        if (bus.rd_start && (rd_st_q != R_IDLE)) cmd_err_d = 1'b1;
        if (rd_abort) begin
            rd_st_d     = R_IDLE;
            key_valid_d = 1'b0;
            tag_v_d     = 1'b0;
            rd_done_d   = 1'b0;
            cmd_err_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!kill_n) begin
            wr_st_q      <= W_IDLE;
            wr_slot_q    <= '0;
            wr_cnt_q     <= '0;
            nr_q         <= '{default: '0};
            slot_valid_q <= '0;
            rd_st_q      <= R_IDLE;
            rd_slot_q    <= '0;
            rd_dec_q     <= 1'b0;
            round_q      <= '0;
            iss_q        <= '0;
            tag_v_q      <= 1'b0;
            tag_w_q      <= '0;
            key_q        <= '0;
            key_valid_q  <= 1'b0;
            rd_done_q    <= 1'b0;
            cmd_err_q    <= 1'b0;
        end else begin
            wr_st_q      <= wr_st_d;
            wr_slot_q    <= wr_slot_d;
            wr_cnt_q     <= wr_cnt_d;
            nr_q         <= nr_d;
            slot_valid_q <= slot_valid_d;
            rd_st_q      <= rd_st_d;
            rd_slot_q    <= rd_slot_d;
            rd_dec_q     <= rd_dec_d;
            round_q      <= round_d;
            iss_q        <= iss_d;
            tag_v_q      <= tag_v_d;
            tag_w_q      <= tag_w_d;
            key_q        <= key_d;
            key_valid_q  <= key_valid_d;
            rd_done_q    <= rd_done_d;
            cmd_err_q    <= cmd_err_d;
        end
    end

    assign bus.wr_busy    = (wr_st_q != W_IDLE);
    assign bus.slot_valid = slot_valid_q;
    assign bus.key_round  = key_q;
    assign bus.key_valid  = key_valid_q;
    assign bus.key_last   = key_last;
    assign bus.rd_done    = rd_done_q;
    assign bus.cmd_err    = cmd_err_q;
    assign bus.ram_we     = ram_we;
    assign bus.ram_addr   = ram_we ? wr_addr : rd_addr;
    assign bus.ram_wdata  = wr_fire ? bus.wr_data : '0;
endmodule

// File: tb/tb_aes_keyram_sched_ctrl.sv
// tb/tb_aes_keyram_sched_ctrl.sv - directed scoreboard bench for aes_keyram_sched_ctrl (RAM_DW=64, 2 slots)
module tb_aes_keyram_sched_ctrl;
    localparam int RAM_DW     = 64;
    localparam int SLOTS      = 2;
    localparam int SLOT_DEPTH = 16;
    localparam int WPR        = 128 / RAM_DW;

    logic clk = 1'b0;
    logic kill_n;
    always #5 clk = ~clk;

    aes_keyram_sched_ctrl_if #(.RAM_DW(RAM_DW), .SLOTS(SLOTS), .SLOT_DEPTH(SLOT_DEPTH)) bus ();
    aes_keyram_sched_ctrl #(.RAM_DW(RAM_DW), .SLOTS(SLOTS), .SLOT_DEPTH(SLOT_DEPTH)) dut (
        .clk    (clk),
        .kill_n (kill_n),
        .bus    (bus)
    );

    logic [63:0] mem [64];
    always @(posedge clk) begin
        if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
        bus.ram_rdata <= mem[bus.ram_addr];
    end

    int n_vec = 0;
    int n_err = 0;
    logic [63:0]  sh [2][32];
    int           nr_sh [2];
    logic [127:0] sb [$];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] want);
        n_vec++;
        assert (obs === want) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, want);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic want);
        n_vec++;
        assert (obs === want) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, want);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int want);
        n_vec++;
        assert (obs === want) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, want);
        end
    endtask

    task automatic push_keys(input int s, input bit dec);
        int r;
        for (int k = 0; k <= nr_sh[s]; k++) begin
            r = dec ? nr_sh[s] - k : k;
            sb.push_back({sh[s][2*r+1], sh[s][2*r]});
        end
    endtask

    task automatic start_rd(input int s, input bit dec);
        bus.rd_start = 1'b1;
        bus.rd_slot  = 1'(s);
        bus.rd_dec   = dec;
        push_keys(s, dec);
        @(negedge clk);
        bus.rd_start = 1'b0;
    endtask

    task automatic consume(input bit chk_lat, input int nmax);
        int lat;
        int taken;
        taken = 0;
        while (sb.size() > 0 && taken < nmax) begin
            logic [127:0] want;
            lat = 0;
            while (!bus.key_valid && lat < 200) begin
                @(negedge clk);
                lat++;
            end
            if (!bus.key_valid) begin
                chkb("key_valid_timeout", bus.key_valid, 1'b1);
                sb.delete();
                return;
            end
            want = sb.pop_front();
            chk("key_round", bus.key_round, want);
            chkb("key_last", bus.key_last, sb.size() == 0);
            if (chk_lat) chki("key_latency", lat, WPR + 1);
            bus.rd_next = 1'b1;
            @(negedge clk);
            bus.rd_next = 1'b0;
            if (sb.size() == 0) begin
                chkb("rd_done", bus.rd_done, 1'b1);
                chkb("key_valid_after_done", bus.key_valid, 1'b0);
            end
            taken++;
        end
    endtask

    task automatic load(input int s, input int klen, input logic [63:0] seed, input bit gap,
                        input bit with_rd, input int probe, input bit exp_err);
        int nw;
        nw = (11 + 2 * klen) * WPR;
        bus.wr_start = 1'b1;
        bus.wr_slot  = 1'(s);
        bus.key_len  = 2'(klen);
        if (with_rd) begin
            bus.rd_start = 1'b1;
            bus.rd_slot  = 1'(s);
            bus.rd_dec   = 1'b0;
        end
        nr_sh[s] = 10 + 2 * klen;
        @(negedge clk);
        bus.wr_start = 1'b0;
        bus.rd_start = 1'b0;
        chkb("wr_busy_start", bus.wr_busy, 1'b1);
        chkb("slot_invalid_on_start", bus.slot_valid[s], 1'b0);
        if (exp_err) begin
            chkb("cmd_err_on_load", bus.cmd_err, 1'b1);
            chkb("key_valid_on_load", bus.key_valid, 1'b0);
            chkb("rd_done_on_load", bus.rd_done, 1'b0);
        end
        for (int i = 0; i < nw; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_data  = seed + 64'(i);
            sh[s][i]     = seed + 64'(i);
            if (i == probe) begin
                bus.rd_start = 1'b1;
                bus.rd_slot  = 1'(s);
            end
            @(negedge clk);
            bus.wr_valid = 1'b0;
            if (i == probe) begin
                bus.rd_start = 1'b0;
                chkb("cmd_err_rd_loading", bus.cmd_err, 1'b1);
                chkb("key_valid_rd_loading", bus.key_valid, 1'b0);
            end
            if (gap) @(negedge clk);
        end
        chkb("wr_busy_end", bus.wr_busy, 1'b0);
        chkb("slot_valid_end", bus.slot_valid[s], 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        kill_n        = 1'b0;
        bus.wr_start  = 1'b0;
        bus.wr_slot   = '0;
        bus.key_len   = '0;
        bus.wr_valid  = 1'b0;
        bus.wr_data   = '0;
        bus.rd_start  = 1'b0;
        bus.rd_slot   = '0;
        bus.rd_dec    = 1'b0;
        bus.rd_next   = 1'b0;
        bus.zero_req  = 1'b0;
        bus.zero_slot = '0;
        repeat (3) @(negedge clk);
        chkb("rst_key_valid", bus.key_valid, 1'b0);
        chk("rst_key_round", bus.key_round, '0);
        chki("rst_slot_valid", int'(bus.slot_valid), 0);
        chkb("rst_wr_busy", bus.wr_busy, 1'b0);
        chkb("rst_cmd_err", bus.cmd_err, 1'b0);
        chkb("rst_ram_we", bus.ram_we, 1'b0);
        kill_n = 1'b1;
        @(negedge clk);

        // AES-128 schedule d[i]=i into slot 0, forward replay
        load(0, 0, 64'd0, 1'b0, 1'b0, -1, 1'b0);
        chki("slot_valid_01", int'(bus.slot_valid), 1);
        start_rd(0, 1'b0);
        consume(1'b1, 99);

        // AES-256 into slot 1 with a rejected rd_start mid-load, then decrypt-order replay
        load(1, 2, 64'h1000, 1'b0, 1'b0, 5, 1'b0);
        chki("slot_valid_11", int'(bus.slot_valid), 3);
        start_rd(1, 1'b1);
        consume(1'b1, 99);

        // illegal key length
        bus.wr_start = 1'b1;
        bus.wr_slot  = 1'b0;
        bus.key_len  = 2'd3;
        @(negedge clk);
        bus.wr_start = 1'b0;
        chkb("cmd_err_keylen3", bus.cmd_err, 1'b1);
        chkb("wr_busy_keylen3", bus.wr_busy, 1'b0);
        chki("slot_valid_keylen3", int'(bus.slot_valid), 3);

        // rd_start while a replay is running is rejected; replay still completes
        start_rd(0, 1'b0);
        bus.rd_start = 1'b1;
        bus.rd_slot  = 1'b1;
        @(negedge clk);
        bus.rd_start = 1'b0;
        chkb("cmd_err_rd_busy", bus.cmd_err, 1'b1);
        consume(1'b0, 99);

        // replay slot 0 while slot 1 reloads with a gap every other cycle
        fork
            load(1, 0, 64'h3000, 1'b1, 1'b0, -1, 1'b0);
            begin
                start_rd(0, 1'b0);
                consume(1'b0, 99);
            end
        join
        chki("slot_valid_after_contend", int'(bus.slot_valid), 3);

        // simultaneous rd_start and wr_start on a valid slot: load wins
        load(1, 0, 64'h4000, 1'b0, 1'b1, -1, 1'b1);
        start_rd(1, 1'b0);
        consume(1'b1, 99);

        // reload of the slot under replay aborts the replay
        start_rd(0, 1'b0);
        repeat (3) @(negedge clk);
        chkb("key_valid_before_abort", bus.key_valid, 1'b1);
        load(0, 0, 64'h2000, 1'b0, 1'b0, -1, 1'b1);
        sb.delete();
        start_rd(0, 1'b1);
        consume(1'b1, 99);

        // reset in the middle of a replay
        start_rd(0, 1'b0);
        consume(1'b1, 2);
        kill_n = 1'b0;
        @(negedge clk);
        kill_n = 1'b1;
        sb.delete();
        chkb("kill_key_valid", bus.key_valid, 1'b0);
        chk("kill_key_round", bus.key_round, '0);
        chki("kill_slot_valid", int'(bus.slot_valid), 0);
        chkb("kill_wr_busy", bus.wr_busy, 1'b0);
        chkb("kill_rd_done", bus.rd_done, 1'b0);
        chkb("kill_key_last", bus.key_last, 1'b0);
        chki("kill_ram_addr", int'(bus.ram_addr), 0);
        bus.rd_start = 1'b1;
        bus.rd_slot  = 1'b0;
        @(negedge clk);
        bus.rd_start = 1'b0;
        chkb("cmd_err_after_kill", bus.cmd_err, 1'b1);
        chkb("key_valid_after_kill", bus.key_valid, 1'b0);
        load(0, 1, 64'h5000, 1'b0, 1'b0, -1, 1'b0);
        start_rd(0, 1'b0);
        consume(1'b1, 99);

        bus.zero_req  = 1'b1;
        bus.zero_slot = 1'b0;
        @(negedge clk);
        bus.zero_req = 1'b0;
`ifdef KEYRAM_ZEROIZE_EN
        chkb("zero_slot_valid", bus.slot_valid[0], 1'b0);
        for (int i = 0; i < SLOT_DEPTH * WPR; i++) begin
            chkb("zero_we", bus.ram_we, 1'b1);
            chki("zero_addr", int'(bus.ram_addr), i);
            chk("zero_wdata", 128'(bus.ram_wdata), '0);
            @(negedge clk);
        end
        chkb("zero_busy_end", bus.wr_busy, 1'b0);
        chkb("zero_slot_valid_end", bus.slot_valid[0], 1'b0);
`else
        chkb("zero_ignored_cmd_err", bus.cmd_err, 1'b0);
        chkb("zero_ignored_we", bus.ram_we, 1'b0);
        chkb("zero_ignored_busy", bus.wr_busy, 1'b0);
        chkb("zero_ignored_slot_valid", bus.slot_valid[0], 1'b1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
